control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Multi-cycle microsequencer that produces the datapath control word.
- Consumes IR_OUT and the ALU status flags from the datapath and drives every control field the datapath takes today.
- Replaces the hand-sequenced control words used in datapath bring-up.
- Implements fetch, decode, execute and load-writeback states for a 16-bit, 16-opcode ISA. Also keeps a retired-instruction counter and a sticky illegal-opcode flag.

Parameters:
- IMM_W, 8, width of the immediate/offset field IR[IMM_W-1:0]. Zero-extended for LDI, sign-extended for branches.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- IR_OUT  in  16  instruction register: opcode[15:12], DA[11:8], SA[7:4], SB[3:0].
- status  in  4  {V,C,N,Z}; Z=status[0], N=status[1].
- NS  out  3  current state code.
- SA, SB, DA  out  4 each  register selects, taken directly from IR_OUT fields.
- WR  out  1  register-file write enable.
- FS  out  5  ALU function select.
- C0  out  1  ALU carry-in.
- DP_RST  out  1  datapath reset; drives the datapath reset input.
- PCSEL, PS[1:0], EN_PC, ENADDRESS_PC  out  PC control.
- EN_ALU, ENADDRESS_ALU, IR_EN, MW, MR, BSEL, ROM_EN  out  1 each  bus and memory strobes.
- K  out  16  constant driven to the datapath B mux.
- retired  out  CNT_W  count of completed instructions.
- illegal  out  1  sticky; set on decode of an undefined opcode.

Behaviour:
- While reset=0: state=RST, DP_RST=1, retired=0, illegal=0, K=0, every other output 0.
- State codes: RST=000, FETCH=001, DECODE=010, EXEC=011, LDWB=100, HALT=111.
- RST lasts exactly one clock after reset deasserts, then goes to FETCH.
- All outputs are combinational from state and IR_OUT. In every state, any control output not listed for that state is 0.
- FETCH: ROM_EN=1, ENADDRESS_PC=1, IR_EN=1. Go to DECODE.
- DECODE: no strobes asserted; opcode sampled.
  - HALT goes to HALT.
  - Every other opcode goes to EXEC.
  - Undefined opcodes set illegal and execute as NOP.
- FS codes: pass A=00000, ADD=00010, SUB=00101, pass B=01000, AND=01100, OR=01101, XOR=01110.
- EXEC asserts, per opcode:
  - 0 NOP: nothing extra.
  - 1 ADD / 2 SUB / 3 AND / 4 OR / 5 XOR: EN_ALU=1, WR=1, FS per table. C0=1 for SUB only.
  - 6 MOV: FS=pass A, EN_ALU=1, WR=1.
  - 7 LDI: BSEL=1, FS=pass B, K=zext(IR[7:0]), EN_ALU=1, WR=1.
  - 8 LD: FS=pass A, EN_ALU=1, ENADDRESS_ALU=1, MR=1. Next state LDWB.
  - 9 ST: FS=pass A, ENADDRESS_ALU=1, MW=1. Data is R[SB].
  - A BZ / B BN: K=sext(IR[7:0]). If the flag (Z or N) is 1, PS=10 and PCSEL=1; otherwise PS=01.
  - C JMP: PS=11, PCSEL=0, PC<-R[SA].
- In EXEC, every non-branch/non-jump opcode also asserts EN_PC=1, PS=01. For LD this is moved to LDWB.
- Branches and JMP assert EN_PC=1.
- LDWB: MR=1, WR=1, EN_PC=1, PS=01. Go to FETCH.
- EXEC (non-LD) goes to FETCH.
- Latency: 3 cycles per instruction; LD takes 4.
- retired increments by 1 on the last cycle of each instruction (EXEC, or LDWB for LD), including NOP and illegal opcodes. It wraps from 2^CNT_W-1 to 0.
- HALT: outputs as DECODE (all strobes 0). Stays in HALT until reset; retired is not incremented.
- Branch flags are sampled combinationally in EXEC. Flags changing in DECODE have no effect.
- Reset asserted mid-instruction (any state) aborts immediately: no WR/MW pulse completes, and retired is not incremented.

Test Plan:
- Reset pulse, release -> NS=000 for 1 cycle with DP_RST=1, then NS=001 with ROM_EN=IR_EN=ENADDRESS_PC=1.
- IR_OUT=16'h1123 (ADD R1,R2,R3) -> in EXEC: FS=00010, WR=1, DA=1, SA=2, SB=3, EN_PC=1, PS=01; retired goes 0->1.
- IR_OUT=16'h750C (LDI R5,#12) -> EXEC: K=16'h000C, BSEL=1, FS=01000, WR=1.
- IR_OUT=16'h8340 (LD R3,[R4]) -> EXEC: MR=1, ENADDRESS_ALU=1, WR=0; LDWB: WR=1, PS=01; 4 cycles total. Follow with 16'h9045 (ST) -> MW=1 for exactly one cycle.
- IR_OUT=16'hA0FC (BZ -4): status=0001 -> PS=10, PCSEL=1, K=16'hFFFC. status=0000 -> PS=01, PCSEL=0.
- IR_OUT=16'hD000 -> illegal=1, behaves as NOP. IR_OUT=16'hF000 -> NS=111 held for 20 cycles, retired frozen. reset=0 during an LD in EXEC -> WR never asserted, retired unchanged.

Source files
------------

// File: rtl/control_sequencer.sv
// Multi-cycle microsequencer: fetch/decode/execute/load-writeback control for the
// 16-bit, 16-opcode datapath. Also keeps a retired-instruction count and a sticky illegal flag.
module control_sequencer #(
    parameter int IMM_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [15:0]      IR_OUT,
    input  logic [3:0]       status,
    output logic [2:0]       NS,
    output logic [3:0]       SA,
    output logic [3:0]       SB,
    output logic [3:0]       DA,
    output logic             WR,
    output logic [4:0]       FS,
    output logic             C0,
    output logic             DP_RST,
    output logic             PCSEL,
    output logic [1:0]       PS,
    output logic             EN_PC,
    output logic             ENADDRESS_PC,
    output logic             EN_ALU,
    output logic             ENADDRESS_ALU,
    output logic             IR_EN,
    output logic             MW,
    output logic             MR,
    output logic             BSEL,
    output logic             ROM_EN,
    output logic [15:0]      K,
    output logic [CNT_W-1:0] retired,
    output logic             illegal
);
    typedef enum logic [2:0] {
        S_RST    = 3'b000,
        S_FETCH  = 3'b001,
        S_DECODE = 3'b010,
        S_EXEC   = 3'b011,
        S_LDWB   = 3'b100,
        S_HALT   = 3'b111
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
                           OP_OR  = 4'h4, OP_XOR = 4'h5, OP_MOV = 4'h6, OP_LDI = 4'h7,
                           OP_LD  = 4'h8, OP_ST  = 4'h9, OP_BZ  = 4'hA, OP_BN  = 4'hB,
                           OP_JMP = 4'hC, OP_HLT = 4'hF;

    localparam logic [4:0] FS_PASSA = 5'b00000, FS_ADD = 5'b00010, FS_SUB = 5'b00101,
                           FS_PASSB = 5'b01000, FS_AND = 5'b01100, FS_OR  = 5'b01101,
                           FS_XOR   = 5'b01110;

    state_t           state, state_nxt;
    logic             retire;
    logic [3:0]       op;
    logic [IMM_W-1:0] imm;
    logic [15:0]      k_zext, k_sext;

    assign op     = IR_OUT[15:12];
    assign imm    = IR_OUT[IMM_W-1:0];
    assign k_zext = 16'(imm);
    assign k_sext = 16'($signed(imm));
    assign NS     = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_RST;
            retired <= '0;
            illegal <= 1'b0;
        end else begin
            state <= state_nxt;
            if (retire)
                retired <= retired + CNT_W'(1);
            // D and E are the only unassigned opcodes; they fall through to EXEC as NOP
            if (state == S_DECODE && (op == 4'hD || op == 4'hE))
                illegal <= 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        retire        = 1'b0;
        {DA, SA, SB}  = '0;
        WR            = 1'b0;
        FS            = FS_PASSA;
        C0            = 1'b0;
        DP_RST        = 1'b0;
        PCSEL         = 1'b0;
        PS            = 2'b00;
        EN_PC         = 1'b0;
        ENADDRESS_PC  = 1'b0;
        EN_ALU        = 1'b0;
        ENADDRESS_ALU = 1'b0;
        IR_EN         = 1'b0;
        MW            = 1'b0;
        MR            = 1'b0;
        BSEL          = 1'b0;
        ROM_EN        = 1'b0;
        K             = '0;
        if (state != S_RST)
            {DA, SA, SB} = IR_OUT[11:0];
        case (state)
            S_RST: begin
                DP_RST    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                ROM_EN       = 1'b1;
                ENADDRESS_PC = 1'b1;
                IR_EN        = 1'b1;
                state_nxt    = S_DECODE;
            end
            S_DECODE: state_nxt = (op == OP_HLT) ? S_HALT : S_EXEC;
            S_EXEC: begin
                retire    = (op != OP_LD);
                state_nxt = (op == OP_LD) ? S_LDWB : S_FETCH;
                EN_PC     = (op != OP_LD);
                PS        = 2'b01;
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV: begin
                        EN_ALU = 1'b1;
                        WR     = 1'b1;
                        C0     = (op == OP_SUB);
                        case (op)
                            OP_ADD:  FS = FS_ADD;
                            OP_SUB:  FS = FS_SUB;
                            OP_AND:  FS = FS_AND;
                            OP_OR:   FS = FS_OR;
                            OP_XOR:  FS = FS_XOR;
                            default: FS = FS_PASSA;
                        endcase
                    end
                    OP_LDI: begin
                        BSEL   = 1'b1;
                        FS     = FS_PASSB;
                        K      = k_zext;
                        EN_ALU = 1'b1;
                        WR     = 1'b1;
                    end
                    OP_LD: begin
                        EN_ALU        = 1'b1;
                        ENADDRESS_ALU = 1'b1;
                        MR            = 1'b1;
                        PS            = 2'b00;
                    end
                    OP_ST: begin
                        ENADDRESS_ALU = 1'b1;
                        MW            = 1'b1;
                    end
                    OP_BZ, OP_BN: begin
                        K = k_sext;
                        // flags are live here: only the value present in EXEC decides the branch
                        if ((op == OP_BZ) ? status[0] : status[1]) begin
                            PS    = 2'b10;
                            PCSEL = 1'b1;
                        end
                    end
                    OP_JMP: PS = 2'b11;
                    default: ;
                endcase
            end
            S_LDWB: begin
                MR        = 1'b1;
                WR        = 1'b1;
                EN_PC     = 1'b1;
                PS        = 2'b01;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_RST;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-opcode EXEC control words from a table,
// plus reset, halt, illegal-opcode and mid-instruction reset sequences.
module tb_control_sequencer;
    localparam int CW = 4;  // narrow counter so the wrap is exercised

    logic          clock = 1'b0;
    logic          reset;
    logic [15:0]   IR_OUT;
    logic [3:0]    status;
    logic [2:0]    NS;
    logic [3:0]    SA, SB, DA;
    logic          WR, C0, DP_RST, PCSEL, EN_PC, ENADDRESS_PC, EN_ALU, ENADDRESS_ALU;
    logic          IR_EN, MW, MR, BSEL, ROM_EN, illegal;
    logic [4:0]    FS;
    logic [1:0]    PS;
    logic [15:0]   K;
    logic [CW-1:0] retired;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    control_sequencer #(.IMM_W(8), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .IR_OUT(IR_OUT), .status(status), .NS(NS),
        .SA(SA), .SB(SB), .DA(DA), .WR(WR), .FS(FS), .C0(C0), .DP_RST(DP_RST),
        .PCSEL(PCSEL), .PS(PS), .EN_PC(EN_PC), .ENADDRESS_PC(ENADDRESS_PC),
        .EN_ALU(EN_ALU), .ENADDRESS_ALU(ENADDRESS_ALU), .IR_EN(IR_EN), .MW(MW), .MR(MR),
        .BSEL(BSEL), .ROM_EN(ROM_EN), .K(K), .retired(retired), .illegal(illegal)
    );

    typedef struct {
        string       nm;
        logic [15:0] ir;
        logic [3:0]  st;
        logic [19:0] ctl;
        logic [15:0] k;
        bit          ld;
    } vec_t;

    // {WR,FS,C0,PCSEL,PS,EN_PC,EN_ALU,ENADDRESS_ALU,MW,MR,BSEL,IR_EN,ROM_EN,ENADDRESS_PC,DP_RST}
    function automatic logic [19:0] mk(input logic wr, input logic [4:0] fs, input logic c0,
        input logic pcsel, input logic [1:0] ps, input logic en_pc, input logic en_alu,
        input logic ea_alu, input logic mw, input logic mr, input logic bsel,
        input logic ir_en, input logic rom_en, input logic ea_pc, input logic dprst);
        return {wr, fs, c0, pcsel, ps, en_pc, en_alu, ea_alu, mw, mr, bsel,
                ir_en, rom_en, ea_pc, dprst};
    endfunction

    function automatic logic [19:0] act_ctl();
        return {WR, FS, C0, PCSEL, PS, EN_PC, EN_ALU, ENADDRESS_ALU, MW, MR, BSEL,
                IR_EN, ROM_EN, ENADDRESS_PC, DP_RST};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic wait_fetch();
        int n = 0;
        while (NS !== 3'b001 && n < 8) begin
            @(negedge clock);
            n++;
        end
        chk("wait_fetch", 32'(NS), 32'd1);
    endtask

    logic [19:0] fetch_ctl, ldwb_ctl, rst_ctl;

    task automatic run_vec(input vec_t v);
        logic [CW-1:0] r0, rexp;
        wait_fetch();
        IR_OUT = v.ir;
        status = v.st;
        #1;
        chk({v.nm, "_fetch"}, 32'(act_ctl()), 32'(fetch_ctl));
        r0 = retired;
        rexp = r0 + 1'b1;
        @(negedge clock);
        status = ~v.st;
        #1;
        chk({v.nm, "_decode"}, {act_ctl(), 9'd0, NS}, {20'd0, 9'd0, 3'd2});
        @(negedge clock);
        status = v.st;
        #1;
        chk({v.nm, "_ns"}, 32'(NS), 32'd3);
        chk({v.nm, "_ctl"}, 32'(act_ctl()), 32'(v.ctl));
        chk({v.nm, "_k"}, 32'(K), 32'(v.k));
        chk({v.nm, "_regs"}, 32'({DA, SA, SB}), 32'(v.ir[11:0]));
        chk({v.nm, "_ret_exec"}, 32'(retired), 32'(r0));
        @(negedge clock);
        if (v.ld) begin
            chk({v.nm, "_ldwb"}, {act_ctl(), 9'd0, NS}, {ldwb_ctl, 9'd0, 3'd4});
            chk({v.nm, "_ret_ldwb"}, 32'(retired), 32'(r0));
            @(negedge clock);
        end
        chk({v.nm, "_next"}, 32'(NS), 32'd1);
        chk({v.nm, "_retired"}, 32'(retired), 32'(rexp));
    endtask

    vec_t vecs[$];

    initial begin
        #400000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        vec_t v, ill;
        logic [CW-1:0] rh;
        fetch_ctl = mk(0, 5'd0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        ldwb_ctl  = mk(1, 5'd0, 0, 0, 2'b01, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        rst_ctl   = mk(0, 5'd0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        //               nm     ir        st     wr fs        c0 pc ps     en al ea mw mr bs
        vecs.push_back('{"add",  16'h1123, 4'h0, mk(1, 5'b00010, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 16'h0000, 0});
        vecs.push_back('{"sub",  16'h2456, 4'h0, mk(1, 5'b00101, 1, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 16'h0000, 0});
        vecs.push_back('{"and",  16'h3111, 4'h0, mk(1, 5'b01100, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 16'h0000, 0});
        vecs.push_back('{"or",   16'h4222, 4'h0, mk(1, 5'b01101, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 16'h0000, 0});
        vecs.push_back('{"xor",  16'h5333, 4'h0, mk(1, 5'b01110, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 16'h0000, 0});
        vecs.push_back('{"mov",  16'h6170, 4'h0, mk(1, 5'b00000, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 16'h0000, 0});
        vecs.push_back('{"ldi",  16'h750C, 4'h0, mk(1, 5'b01000, 0, 0, 2'b01, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0), 16'h000C, 0});
        vecs.push_back('{"ldiff",16'h7AFF, 4'h0, mk(1, 5'b01000, 0, 0, 2'b01, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0), 16'h00FF, 0});
        vecs.push_back('{"ld",   16'h8340, 4'h0, mk(0, 5'b00000, 0, 0, 2'b00, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0), 16'h0000, 1});
        vecs.push_back('{"st",   16'h9045, 4'h0, mk(0, 5'b00000, 0, 0, 2'b01, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0), 16'h0000, 0});
        vecs.push_back('{"nop",  16'h0000, 4'h0, mk(0, 5'b00000, 0, 0, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 16'h0000, 0});
        vecs.push_back('{"bz_t", 16'hA0FC, 4'h1, mk(0, 5'b00000, 0, 1, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 16'hFFFC, 0});
        vecs.push_back('{"bz_n", 16'hA0FC, 4'h0, mk(0, 5'b00000, 0, 0, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 16'hFFFC, 0});
        vecs.push_back('{"bn_t", 16'hB005, 4'h2, mk(0, 5'b00000, 0, 1, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 16'h0005, 0});
        vecs.push_back('{"bn_n", 16'hB005, 4'hD, mk(0, 5'b00000, 0, 0, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 16'h0005, 0});
        vecs.push_back('{"bz_80",16'hA080, 4'hF, mk(0, 5'b00000, 0, 1, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 16'hFF80, 0});
        vecs.push_back('{"jmp",  16'hC020, 4'hF, mk(0, 5'b00000, 0, 0, 2'b11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 16'h0000, 0});
        vecs.push_back('{"ld2",  16'h8A70, 4'h0, mk(0, 5'b00000, 0, 0, 2'b00, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0), 16'h0000, 1});

        // reset state
        reset  = 1'b0;
        IR_OUT = 16'h1234;
        status = 4'h0;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_ns", 32'(NS), 32'd0);
        chk("rst_ctl", 32'(act_ctl()), 32'(rst_ctl));
        chk("rst_k_regs", {K, DA, SA, SB}, 32'd0);
        chk("rst_ret_ill", {retired, illegal}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_hold_one", {NS, DP_RST}, 32'd1);
        @(negedge clock);
        chk("rst_to_fetch", 32'(NS), 32'd1);
        chk("fetch_ctl", 32'(act_ctl()), 32'(fetch_ctl));

        foreach (vecs[i]) run_vec(vecs[i]);
        chk("illegal_clean", 32'(illegal), 32'd0);

        ill = '{"ill_d", 16'hD000, 4'h0, mk(0, 5'b00000, 0, 0, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 16'h0000, 0};
        run_vec(ill);
        chk("illegal_set", 32'(illegal), 32'd1);
        run_vec(vecs[0]);
        chk("illegal_sticky", 32'(illegal), 32'd1);

        // halt holds with counter frozen
        wait_fetch();
        IR_OUT = 16'hF000;
        rh = retired;
        @(negedge clock);
        @(negedge clock);
        for (int i = 0; i < 20; i++) begin
            chk("halt_hold", {act_ctl(), 1'b0, NS, 4'(retired)}, {20'd0, 1'b0, 3'd7, 4'(rh)});
            @(negedge clock);
        end

        // reset in the middle of an LD: no writeback, counter cleared
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        wait_fetch();
        IR_OUT = 16'h8340;
        @(negedge clock);
        @(negedge clock);
        chk("ld_exec_mr", {NS, MR, WR}, {27'd0, 3'd3, 1'b1, 1'b0});
        #2 reset = 1'b0;
        #1;
        chk("abort_now", {NS, WR, 4'(retired)}, {24'd0, 3'd0, 1'b0, 4'd0});
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("abort_nowr", {WR, MW, 4'(retired)}, 32'd0);
        end
        reset = 1'b1;
        #1;
        chk("abort_rst_ns", 32'(NS), 32'd0);
        @(negedge clock);
        chk("abort_refetch", {NS, 4'(retired)}, {25'd0, 3'd1, 4'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
